// File: rtl/paddle_input_conditioner.sv
`default_nettype none
//============================================================================
// Module      : paddle_input_conditioner (with helper paddle_input_channel)
// Description : Front end for the two paddle buttons of the ping-pong game.
//               Each raw, asynchronous, bouncy button goes through a 2-flop
//               synchroniser and a counter debouncer. The result is a clean
//               level plus one-cycle press, release and long-hold pulses.
//               both_press marks a press of both buttons in the same cycle.
// Ports       : clk, reset (sync, active-high)
//               P1, P2                  raw buttons (async, active-high)
//               p1_level, p2_level      debounced levels
//               p1_press, p2_press      1-cycle pulse on debounced 0->1
//               p1_release, p2_release  1-cycle pulse on debounced 1->0
//               p1_hold, p2_hold        1-cycle pulse once per long press
//               both_press              p1_press and p2_press together
// Revision    : 1.0 - initial release
//============================================================================

//----------------------------------------------------------------------------
// paddle_input_channel: one button. It contains the synchroniser, the
// debounce FSM and the hold timer. All outputs are registered.
// press_next is the unregistered press condition. The top level uses it to
// build a registered both_press that lines up with the press pulses.
//----------------------------------------------------------------------------
module paddle_input_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned CNT_W           = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic hold,
    output logic press_next
);

    localparam logic [CNT_W-1:0] c_ZERO      = '0;
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic             c_HOLD_ONE  = (HOLD_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // level 0, input low
        ST_ARM     = 2'd1,  // level 0, counting stable-high cycles
        ST_PRESSED = 2'd2,  // level 1, input high
        ST_DISARM  = 2'd3   // level 1, counting stable-low cycles
    } state_t;

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_n;
    logic [CNT_W-1:0] w_hold_inc;
    logic             r_fired;
    logic             w_fired_n;
    logic             r_level;
    logic             w_level_n;
    logic             r_press;
    logic             w_press_n;
    logic             r_rel;
    logic             w_rel_n;
    logic             r_hold;
    logic             w_hold_n;

    // Saturating increment: the hold timer parks at its last value and
    // never wraps.
    assign w_hold_inc = (r_hold_cnt == c_HOLD_LAST) ? r_hold_cnt
                                                    : r_hold_cnt + c_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_state    <= ST_IDLE;
            r_cnt      <= c_ZERO;
            r_hold_cnt <= c_ZERO;
            r_fired    <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_rel      <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_s1       <= raw;
            r_s2       <= r_s1;
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_hold_cnt <= w_hold_cnt_n;
            r_fired    <= w_fired_n;
            r_level    <= w_level_n;
            r_press    <= w_press_n;
            r_rel      <= w_rel_n;
            r_hold     <= w_hold_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_hold_cnt_n = r_hold_cnt;
        w_fired_n    = r_fired;
        w_level_n    = r_level;
        w_press_n    = 1'b0;
        w_rel_n      = 1'b0;
        w_hold_n     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_s2) begin
                    w_state_n = ST_ARM;
                    w_cnt_n   = c_ONE;
                end
            end
            ST_ARM: begin
                if (!r_s2) begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = c_ZERO;
                end else if (r_cnt == c_DB_LAST) begin
                    w_state_n    = ST_PRESSED;
                    w_level_n    = 1'b1;
                    w_press_n    = 1'b1;
                    w_hold_cnt_n = c_ZERO;
                    // A one-cycle hold time is already met on the first
                    // pressed cycle.
                    w_hold_n     = c_HOLD_ONE;
                    w_fired_n    = c_HOLD_ONE;
                end else begin
                    w_cnt_n = r_cnt + c_ONE;
                end
            end
            ST_PRESSED: begin
                if (!r_s2) begin
                    w_state_n = ST_DISARM;
                    w_cnt_n   = c_ONE;
                end
            end
            ST_DISARM: begin
                if (r_s2) begin
                    w_state_n = ST_PRESSED;
                    w_cnt_n   = c_ZERO;
                end else if (r_cnt == c_DB_LAST) begin
                    w_state_n = ST_IDLE;
                    w_level_n = 1'b0;
                    w_rel_n   = 1'b1;
                    w_fired_n = 1'b0;
                end else begin
                    w_cnt_n = r_cnt + c_ONE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_cnt_n   = c_ZERO;
                w_level_n = 1'b0;
            end
        endcase

        // The hold timer runs for as long as the debounced level stays
        // high. A bounce that is still being debounced (DISARM) does not
        // stop the timer. The timer is frozen on the cycle the level drops.
        if ((r_state == ST_PRESSED || r_state == ST_DISARM) &&
            (w_state_n == ST_PRESSED || w_state_n == ST_DISARM)) begin
            w_hold_cnt_n = w_hold_inc;
            if (w_hold_inc == c_HOLD_LAST && !r_fired) begin
                w_hold_n  = 1'b1;
                w_fired_n = 1'b1;
            end
        end
    end

    assign level      = r_level;
    assign press      = r_press;
    assign rel        = r_rel;
    assign hold       = r_hold;
    assign press_next = w_press_n;

endmodule

//----------------------------------------------------------------------------
// Top level: two independent channels plus the registered both_press.
//----------------------------------------------------------------------------
module paddle_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned CNT_W           = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic P1,
    input  logic P2,
    output logic p1_level,
    output logic p2_level,
    output logic p1_press,
    output logic p2_press,
    output logic p1_release,
    output logic p2_release,
    output logic p1_hold,
    output logic p2_hold,
    output logic both_press
);

    logic w_p1_press_next;
    logic w_p2_press_next;
    logic r_both_press;

    paddle_input_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .CNT_W           (CNT_W)
    ) u_p1 (
        .clk        (clk),
        .reset      (reset),
        .raw        (P1),
        .level      (p1_level),
        .press      (p1_press),
        .rel        (p1_release),
        .hold       (p1_hold),
        .press_next (w_p1_press_next)
    );

    paddle_input_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .CNT_W           (CNT_W)
    ) u_p2 (
        .clk        (clk),
        .reset      (reset),
        .raw        (P2),
        .level      (p2_level),
        .press      (p2_press),
        .rel        (p2_release),
        .hold       (p2_hold),
        .press_next (w_p2_press_next)
    );

    // Register the AND of the two next-press conditions, not of the
    // registered pulses. This keeps both_press in the same cycle as the
    // press pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_both_press <= 1'b0;
        end else begin
            r_both_press <= w_p1_press_next & w_p2_press_next;
        end
    end

    assign both_press = r_both_press;

endmodule
`default_nettype wire

// File: tb/tb_paddle_input_conditioner.sv
`default_nettype none
//============================================================================
// Module      : tb_paddle_input_conditioner
// Description : Self-checking bench for paddle_input_conditioner with
//               DEBOUNCE_CYCLES=4 and HOLD_CYCLES=10. The stimulus pushes
//               the expected output vector for every cycle into a
//               scoreboard. A monitor on the falling edge pops each entry
//               and compares it with the outputs.
// Revision    : 1.0 - initial release
//============================================================================
module tb_paddle_input_conditioner;

    localparam int unsigned c_DEB  = 4;
    localparam int unsigned c_HOLD = 10;

    // Output vector bit masks
    localparam logic [8:0] c_L1   = 9'h001;
    localparam logic [8:0] c_L2   = 9'h002;
    localparam logic [8:0] c_PR1  = 9'h004;
    localparam logic [8:0] c_PR2  = 9'h008;
    localparam logic [8:0] c_RE1  = 9'h010;
    localparam logic [8:0] c_RE2  = 9'h020;
    localparam logic [8:0] c_H1   = 9'h040;
    localparam logic [8:0] c_BOTH = 9'h100;
    localparam logic [8:0] c_NONE = 9'h000;

    logic clk;
    logic reset;
    logic P1;
    logic P2;
    logic p1_level, p2_level, p1_press, p2_press;
    logic p1_release, p2_release, p1_hold, p2_hold, both_press;
    logic [8:0] outs;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_err  = 0;
    int exp_next = 1;
    int c;

    typedef struct {
        int         cyc;
        logic [8:0] v;
    } exp_t;
    exp_t sb[$];

    paddle_input_conditioner #(
        .DEBOUNCE_CYCLES (c_DEB),
        .HOLD_CYCLES     (c_HOLD),
        .CNT_W           (27)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .P1         (P1),
        .P2         (P2),
        .p1_level   (p1_level),
        .p2_level   (p2_level),
        .p1_press   (p1_press),
        .p2_press   (p2_press),
        .p1_release (p1_release),
        .p2_release (p2_release),
        .p1_hold    (p1_hold),
        .p2_hold    (p2_hold),
        .both_press (both_press)
    );

    assign outs = {both_press, p2_hold, p1_hold, p2_release, p1_release,
                   p2_press, p1_press, p2_level, p1_level};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Queue the expected vector v for every cycle from exp_next to last.
    task automatic push_upto(input int last, input logic [8:0] v);
        while (exp_next <= last) begin
            sb.push_back('{cyc: exp_next, v: v});
            exp_next++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // cyc is the number of rising edges seen. The outputs observed here
    // are the state left by edge number cyc.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check($sformatf("cyc%0d", cyc), {23'd0, outs}, {23'd0, e.v});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Inputs driven while cyc==c are sampled at edge c+1. A clean edge
    // shows up on the outputs at cycle c+6 (2 sync + 4 debounce).
    initial begin
        // 1: reset with both buttons high, then a clean simultaneous press
        reset = 1'b1; P1 = 1'b1; P2 = 1'b1;
        push_upto(3, c_NONE);
        tick(3);
        reset = 1'b0; c = cyc;
        push_upto(c + 5, c_NONE);
        push_upto(c + 6, c_L1 | c_L2 | c_PR1 | c_PR2 | c_BOTH);
        push_upto(c + 7, c_L1 | c_L2);
        tick(7);
        P1 = 1'b0; P2 = 1'b0; c = cyc;
        push_upto(c + 5, c_L1 | c_L2);
        push_upto(c + 6, c_RE1 | c_RE2);
        push_upto(c + 7, c_NONE);
        tick(7);

        // 2+3: bounce 1,0,1,0 then stable 1; hold once; release
        c = cyc;
        push_upto(c + 9,  c_NONE);
        push_upto(c + 10, c_L1 | c_PR1);
        push_upto(c + 18, c_L1);
        push_upto(c + 19, c_L1 | c_H1);
        push_upto(c + 34, c_L1);
        push_upto(c + 35, c_RE1);
        push_upto(c + 36, c_NONE);
        P1 = 1'b1; tick(1);
        P1 = 1'b0; tick(1);
        P1 = 1'b1; tick(1);
        P1 = 1'b0; tick(1);
        P1 = 1'b1; tick(25);
        P1 = 1'b0; tick(7);

        // 4a: both rise in the same cycle
        c = cyc;
        push_upto(c + 5, c_NONE);
        push_upto(c + 6, c_L1 | c_L2 | c_PR1 | c_PR2 | c_BOTH);
        P1 = 1'b1; P2 = 1'b1; tick(6);
        P1 = 1'b0; P2 = 1'b0;
        push_upto(c + 11, c_L1 | c_L2);
        push_upto(c + 12, c_RE1 | c_RE2);
        push_upto(c + 13, c_NONE);
        tick(7);

        // 4b: P2 one cycle late, so both_press stays low
        c = cyc;
        push_upto(c + 5, c_NONE);
        push_upto(c + 6, c_L1 | c_PR1);
        push_upto(c + 7, c_L1 | c_L2 | c_PR2);
        P1 = 1'b1; tick(1);
        P2 = 1'b1; tick(6);
        P1 = 1'b0; P2 = 1'b0;
        push_upto(c + 12, c_L1 | c_L2);
        push_upto(c + 13, c_RE1 | c_RE2);
        push_upto(c + 14, c_NONE);
        tick(7);

        // 5: glitch three synced cycles long is rejected
        c = cyc;
        push_upto(c + 10, c_NONE);
        P1 = 1'b1; tick(3);
        P1 = 1'b0; tick(7);

        // 6: reset on the 8th pressed cycle discards the hold and release
        c = cyc;
        push_upto(c + 5,  c_NONE);
        push_upto(c + 6,  c_L1 | c_PR1);
        push_upto(c + 12, c_L1);
        push_upto(c + 22, c_NONE);
        P1 = 1'b1; tick(12);
        reset = 1'b1; P1 = 1'b0; tick(2);
        reset = 1'b0; tick(8);

        tick(2);
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
